// File: rtl/spi_reg_sequencer.sv
// SPI mode-0 slave frame controller: command byte (R/W + addr) then data byte(s) -> register strobes.
// Optional SPI_AUTOINC_EN: stream consecutive data bytes with auto-incrementing address.
module spi_reg_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, CMD, FETCH, DATA, HOLD} state_e;

  logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic       sclk_dly_q, cs_dly_q;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d, rx_shift;
  logic       rd_q, rd_d, fetch_q, fetch_d, adv_q, adv_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d, re_q, re_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      sclk_dly_q  <= sclk_sync_q[1];
      cs_dly_q    <= cs_sync_q[1];
    end
  end

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign rx_shift  = {rx_q[6:0], mosi_s};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rd_d      = rd_q;
    fetch_d   = fetch_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    adv_d     = 1'b0;
    // Write-byte address advance is deferred one cycle so reg_addr stays valid under reg_we.
    if (adv_q) addr_d = addr_q + 7'd1;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = CMD;
          bit_cnt_d = 3'd0;
          tx_d      = 8'h00;
        end
      end
      CMD: begin
        if (cs_rise) state_d = IDLE;
        else if (sclk_rise) begin
          rx_d      = rx_shift;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_d = rx_shift[6:0];
            rd_d   = rx_shift[7];
            if (rx_shift[7]) begin
              re_d    = 1'b1;
              fetch_d = 1'b0;
              state_d = FETCH;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      FETCH: begin
        // First cycle carries reg_re; read data is captured on the second.
        if (cs_rise) state_d = IDLE;
        else if (!fetch_q) fetch_d = 1'b1;
        else begin
          tx_d    = reg_rdata;
          state_d = DATA;
        end
      end
      DATA: begin
        if (cs_rise) state_d = IDLE;
        else begin
          if (sclk_fall && bit_cnt_q != 3'd0) tx_d = {tx_q[6:0], 1'b0};
          if (sclk_rise) begin
            rx_d      = rx_shift;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (!rd_q) begin
                we_d    = 1'b1;
                wdata_d = rx_shift;
              end
`ifdef SPI_AUTOINC_EN
              if (rd_q) begin
                addr_d  = addr_q + 7'd1;
                re_d    = 1'b1;
                fetch_d = 1'b0;
                state_d = FETCH;
              end else begin
                adv_d   = 1'b1;
              end
`else
              state_d = HOLD;
`endif
            end
          end
        end
      end
      HOLD: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      rx_q      <= 8'h00;
      tx_q      <= 8'h00;
      rd_q      <= 1'b0;
      fetch_q   <= 1'b0;
      adv_q     <= 1'b0;
      addr_q    <= 7'h00;
      wdata_q   <= 8'h00;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      rd_q      <= rd_d;
      fetch_q   <= fetch_d;
      adv_q     <= adv_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
    end
  end

  assign miso      = (state_q == DATA && !cs_s) ? tx_q[7] : 1'b0;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Randomized SPI master + register bank; strobes scored against a frame-level model.
module tb_spi_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       miso, reg_we, reg_re, busy;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic wr; logic [6:0] a; logic [7:0] d;} ev_t;
  ev_t exp_q[$];

  logic [7:0] bank_mem [128];
  logic [7:0] model_mem[128];
  logic [7:0] txd[3];

  spi_reg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Peripheral register bank: read data appears the cycle after reg_re.
  always @(posedge clk) begin
    if (reg_we) bank_mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= bank_mem[reg_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && (reg_we || reg_re)) begin
      chk("we_re_exclusive", {31'd0, reg_we & reg_re}, 32'd0);
      if (exp_q.size() == 0) chk("unexpected_strobe", {reg_we, reg_re, reg_addr}, 32'd0);
      else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("strobe_kind", {30'd0, reg_we, reg_re}, {30'd0, e.wr, ~e.wr});
        chk("strobe_addr", {25'd0, reg_addr}, {25'd0, e.a});
        if (e.wr) chk("strobe_wdata", {24'd0, reg_wdata}, {24'd0, e.d});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ev(input logic wr, input logic [6:0] a, input logic [7:0] d);
    ev_t e;
    e.wr = wr; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  // One frame: command byte plus nbits data bits from txd[]. coincide raises cs_n together
  // with the last sclk rise; rst_mid pulses reset while the frame is open.
  task automatic run_frame(input logic [7:0] cmd, input int nbits, input bit coincide,
                           input bit rst_mid);
    int half, full, per;
    logic [6:0] a, ak;
    logic [7:0] got;
    logic [7:0] expm[3];
    half = $urandom_range(5, 8);
    a = cmd[6:0];
    full = coincide ? nbits / 8 - 1 : nbits / 8;
    if (rst_mid) full = 0;
    per = full;
`ifndef SPI_AUTOINC_EN
    if (per > 1) per = 1;
`endif
    for (int k = 0; k < 3; k++) begin
      ak = a + 7'(k);
      expm[k] = 8'h00;
      if (cmd[7]) begin
`ifdef SPI_AUTOINC_EN
        expm[k] = model_mem[ak];
`else
        if (k == 0) expm[k] = model_mem[a];
`endif
      end
    end
    if (cmd[7]) begin
      if (!rst_mid) push_ev(1'b0, a, 8'h00);
`ifdef SPI_AUTOINC_EN
      for (int k = 0; k < full; k++) push_ev(1'b0, a + 7'(k + 1), 8'h00);
`endif
    end else begin
      for (int k = 0; k < per; k++) begin
        ak = a + 7'(k);
        push_ev(1'b1, ak, txd[k]);
        model_mem[ak] = txd[k];
      end
    end

    cs_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mosi = cmd[7-i];
      tick(half);
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
    end
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = txd[i/8][7-(i%8)];
      tick(half);
      got[7-(i%8)] = miso;
      sclk = 1'b1;
      if (coincide && i == nbits - 1) begin
        cs_n = 1'b1;
        tick(4);
        chk("busy_after_coincident_cs", {31'd0, busy}, 32'd0);
        tick(half - 4);
      end else begin
        tick(half);
      end
      sclk = 1'b0;
      if (i % 8 == 7 && i / 8 < full) chk("miso_byte", {24'd0, got}, {24'd0, expm[i/8]});
    end
    if (rst_mid) begin
      rst_n = 1'b0;
      #1;
      chk("outputs_in_reset", {20'd0, miso, reg_addr, reg_wdata, reg_we, reg_re, busy}, 32'd0);
      cs_n = 1'b1;
      mosi = 1'b0;
      tick(3);
      rst_n = 1'b1;
    end else begin
      tick(half);
      cs_n = 1'b1;
    end
    tick(10);
    chk("frame_idle", {31'd0, busy}, 32'd0);
    chk("strobes_outstanding", exp_q.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      bank_mem[i]  = 8'($urandom);
      model_mem[i] = bank_mem[i];
    end
    tick(3);
    chk("reset_outputs", {20'd0, miso, reg_addr, reg_wdata, reg_we, reg_re, busy}, 32'd0);
    rst_n = 1'b1;
    tick(5);
    chk("idle_after_reset", {20'd0, miso, reg_addr, reg_wdata, reg_we, reg_re, busy}, 32'd0);

    txd[0] = 8'hA5; txd[1] = 8'h00; txd[2] = 8'h00;
    run_frame(8'h05, 8, 1'b0, 1'b0);
    bank_mem[3] = 8'h3C; model_mem[3] = 8'h3C;
    run_frame(8'h83, 8, 1'b0, 1'b0);
    txd[0] = 8'h99;
    run_frame(8'h10, 4, 1'b0, 1'b0);
    txd[0] = 8'h22;
    run_frame(8'h11, 8, 1'b0, 1'b0);
    txd[0] = 8'h01; txd[1] = 8'h02;
    run_frame(8'h7F, 16, 1'b0, 1'b0);
    txd[0] = 8'h5A;
    run_frame(8'h20, 8, 1'b1, 1'b0);
    txd[0] = 8'hC3;
    run_frame(8'h21, 4, 1'b0, 1'b1);
    txd[0] = 8'h66;
    run_frame(8'h21, 8, 1'b0, 1'b0);
    run_frame(8'hA1, 8, 1'b0, 1'b0);
    run_frame(8'hFF, 16, 1'b0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      logic [7:0] cmd;
      int nb, nbits;
      bit co;
      cmd = 8'($urandom);
      nb = $urandom_range(1, 3);
      nbits = 8 * nb;
      co = 1'b0;
      for (int k = 0; k < 3; k++) txd[k] = 8'($urandom);
      case ($urandom_range(0, 7))
        0: nbits = $urandom_range(1, 8 * nb - 1);
        1: co = 1'b1;
        default: ;
      endcase
      run_frame(cmd, nbits, co, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
